// File: rtl/led_mat_pkg.sv
// Shared types and sizing helpers for the LED_MAT3 HUB scan path.
// Default-configuration widths are kept here; modules derive their own from parameters.
package led_mat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_BLANK,
    ST_DISPLAY
  } scan_state_e;

  localparam logic LATCH_ICN2038 = 1'b1;
  localparam logic LATCH_MBI5124 = 1'b0;

  // Index width for n items, never below one bit.
  function automatic int unsigned bits_for(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Wide enough to hold BASE_TICKS << (planes-1) without wrapping.
  function automatic int unsigned disp_cnt_bits(input int unsigned base_ticks,
                                                input int unsigned planes);
    return $clog2(base_ticks) + planes;
  endfunction

  localparam int unsigned ROW_BITS      = bits_for(30);
  localparam int unsigned PLANE_BITS    = bits_for(8);
  localparam int unsigned DISP_CNT_BITS = disp_cnt_bits(16, 8);

endpackage

// File: rtl/hub_bcm_timer.sv
// Binary-code-modulation display timer: loaded with (BASE_TICKS << plane) - 1,
// counts down to zero; done is high on the final display cycle.
module hub_bcm_timer
  import led_mat_pkg::*;
#(
  parameter int unsigned PLANES     = 8,
  parameter int unsigned BASE_TICKS = 16,
  localparam int unsigned PLANE_W   = bits_for(PLANES),
  localparam int unsigned DISP_W    = disp_cnt_bits(BASE_TICKS, PLANES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [PLANE_W-1:0] plane,
  output logic               done
);

  logic [DISP_W-1:0] cnt;
  logic [DISP_W-1:0] base_v;

  assign base_v = DISP_W'(BASE_TICKS);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (base_v << plane) - DISP_W'(1);
    end else if (cnt != '0) begin
      cnt <= cnt - DISP_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/hub_scan_ctrl.sv
// HUB scan sequencer: per row, per bit plane: shift a row, blank, latch,
// update row address, then display for BASE_TICKS << plane cycles.
module hub_scan_ctrl
  import led_mat_pkg::*;
#(
  parameter int unsigned COLS         = 120,
  parameter int unsigned ROWS         = 30,
  parameter int unsigned PLANES       = 8,
  parameter int unsigned BASE_TICKS   = 16,
  parameter int unsigned BLANK_CYCLES = 4,
  localparam int unsigned ROW_W       = bits_for(ROWS),
  localparam int unsigned COL_W       = bits_for(COLS),
  localparam int unsigned PLANE_W     = bits_for(PLANES),
  localparam int unsigned SH_W        = COL_W + 1,
  localparam int unsigned BLK_W       = bits_for(BLANK_CYCLES)
) (
  input  logic               MCLK_IN,
  input  logic               RESET,
  input  logic               ENABLE,
  input  logic               LATCH_POS,
  output logic               RD_EN,
  output logic [ROW_W-1:0]   RD_ROW,
  output logic [COL_W-1:0]   RD_COL,
  output logic [PLANE_W-1:0] RD_PLANE,
  output logic               HUB_CLK,
  output logic               HUB_LATCH,
  output logic               HUB_OE,
  output logic [4:0]         HUB_ADDR,
  output logic               FRAME_DONE,
  output logic               BUSY
);

  localparam logic [SH_W-1:0]    SH_LAST    = SH_W'(2 * COLS - 1);
  localparam logic [SH_W-1:0]    SH_LATCH   = SH_W'(2 * COLS - 2);
  localparam logic [BLK_W-1:0]   BLK_LAST   = BLK_W'(BLANK_CYCLES - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(PLANES - 1);

  scan_state_e        state, state_n;
  logic [SH_W-1:0]    sh_cnt, sh_cnt_n;
  logic [BLK_W-1:0]   blk_cnt, blk_cnt_n;
  logic [ROW_W-1:0]   row, row_n;
  logic [PLANE_W-1:0] plane, plane_n;
  logic               lpos, lpos_n;
  logic               tmr_load, tmr_done;
  logic               frame_done_n, first_blank, latch_n;

  hub_bcm_timer #(
    .PLANES     (PLANES),
    .BASE_TICKS (BASE_TICKS)
  ) u_timer (
    .clk   (MCLK_IN),
    .rst   (RESET),
    .load  (tmr_load),
    .plane (plane),
    .done  (tmr_done)
  );

  always_comb begin
    state_n      = state;
    sh_cnt_n     = sh_cnt;
    blk_cnt_n    = blk_cnt;
    row_n        = row;
    plane_n      = plane;
    lpos_n       = lpos;
    tmr_load     = 1'b0;
    frame_done_n = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (ENABLE) begin
          lpos_n   = LATCH_POS;
          row_n    = '0;
          plane_n  = '0;
          sh_cnt_n = '0;
          state_n  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sh_cnt == SH_LAST) begin
          blk_cnt_n = '0;
          state_n   = ST_BLANK;
        end else begin
          sh_cnt_n = sh_cnt + SH_W'(1);
        end
      end
      ST_BLANK: begin
        if (blk_cnt == BLK_LAST) begin
          tmr_load = 1'b1;
          state_n  = ST_DISPLAY;
        end else begin
          blk_cnt_n = blk_cnt + BLK_W'(1);
        end
      end
      ST_DISPLAY: begin
        if (tmr_done) begin
          sh_cnt_n = '0;
          state_n  = ST_SHIFT;
          if (plane != PLANE_LAST) begin
            plane_n = plane + PLANE_W'(1);
          end else begin
            plane_n = '0;
            if (row != ROW_LAST) begin
              row_n = row + ROW_W'(1);
            end else begin
              // Frame boundary: the only point where ENABLE and LATCH_POS take effect.
              row_n        = '0;
              frame_done_n = 1'b1;
              if (ENABLE) lpos_n = LATCH_POS;
              else        state_n = ST_IDLE;
            end
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    first_blank = (state == ST_SHIFT) && (state_n == ST_BLANK);
    latch_n     = ((state_n == ST_SHIFT) && (lpos_n == LATCH_ICN2038) && (sh_cnt_n >= SH_LATCH))
               || (first_blank && (lpos_n == LATCH_MBI5124));
  end

  // RD_EN is a one-cycle read strobe for column RD_COL; the line buffer returns
  // data one cycle later, i.e. during the HUB_CLK=1 half of that column pair.
  always_ff @(posedge MCLK_IN) begin
    if (RESET) begin
      state      <= ST_IDLE;
      sh_cnt     <= '0;
      blk_cnt    <= '0;
      row        <= '0;
      plane      <= '0;
      lpos       <= 1'b0;
      RD_EN      <= 1'b0;
      RD_ROW     <= '0;
      RD_COL     <= '0;
      RD_PLANE   <= '0;
      HUB_CLK    <= 1'b0;
      HUB_LATCH  <= 1'b0;
      HUB_OE     <= 1'b1;
      HUB_ADDR   <= '0;
      FRAME_DONE <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      state      <= state_n;
      sh_cnt     <= sh_cnt_n;
      blk_cnt    <= blk_cnt_n;
      row        <= row_n;
      plane      <= plane_n;
      lpos       <= lpos_n;
      RD_EN      <= (state_n == ST_SHIFT) && !sh_cnt_n[0];
      RD_COL     <= (state_n == ST_SHIFT) ? sh_cnt_n[SH_W-1:1] : '0;
      RD_ROW     <= row_n;
      RD_PLANE   <= plane_n;
      HUB_CLK    <= (state_n == ST_SHIFT) && sh_cnt_n[0];
      HUB_LATCH  <= latch_n;
      HUB_OE     <= (state_n != ST_DISPLAY);
      if (first_blank) HUB_ADDR <= 5'(row_n);
      FRAME_DONE <= frame_done_n;
      BUSY       <= (state_n != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_hub_scan_ctrl.sv
// Directed bench for hub_scan_ctrl in the small COLS=4/ROWS=2/PLANES=2 configuration;
// the reference model decodes outputs from the position within the frame.
module tb_hub_scan_ctrl;

  localparam int COLS         = 4;
  localparam int ROWS         = 2;
  localparam int PLANES       = 2;
  localparam int BASE_TICKS   = 3;
  localparam int BLANK_CYCLES = 2;
  localparam int ROW_W   = (ROWS <= 1) ? 1 : $clog2(ROWS);
  localparam int COL_W   = (COLS <= 1) ? 1 : $clog2(COLS);
  localparam int PLANE_W = (PLANES <= 1) ? 1 : $clog2(PLANES);
  localparam int FRAME   = ROWS * (PLANES * (2 * COLS + BLANK_CYCLES) + BASE_TICKS * ((1 << PLANES) - 1));
  localparam int VW      = 1 + ROW_W + COL_W + PLANE_W + 3 + 5 + 2;

  logic               clk = 1'b0;
  logic               rst, enable, latch_pos;
  logic               rd_en, hub_clk, hub_latch, hub_oe, frame_done, busy;
  logic [ROW_W-1:0]   rd_row;
  logic [COL_W-1:0]   rd_col;
  logic [PLANE_W-1:0] rd_plane;
  logic [4:0]         hub_addr;
  logic [VW-1:0]      dut_vec;

  always #5 clk = ~clk;

  hub_scan_ctrl #(
    .COLS (COLS), .ROWS (ROWS), .PLANES (PLANES),
    .BASE_TICKS (BASE_TICKS), .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .MCLK_IN (clk), .RESET (rst), .ENABLE (enable), .LATCH_POS (latch_pos),
    .RD_EN (rd_en), .RD_ROW (rd_row), .RD_COL (rd_col), .RD_PLANE (rd_plane),
    .HUB_CLK (hub_clk), .HUB_LATCH (hub_latch), .HUB_OE (hub_oe), .HUB_ADDR (hub_addr),
    .FRAME_DONE (frame_done), .BUSY (busy)
  );

  assign dut_vec = {rd_en, rd_row, rd_col, rd_plane, hub_clk, hub_latch, hub_oe,
                    hub_addr, frame_done, busy};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [VW-1:0] exp_q[$];

  bit         m_on;
  int         m_pos;
  logic       m_lp;
  logic [4:0] m_addr;
  logic       m_fd;

  int   clk_rise, oe_low, latch_cnt, latch_clk, last_fd;
  bit   gap_chk;
  logic prev_clk;

  task automatic build_exp(output logic [VW-1:0] v);
    logic e_rd_en, e_clk, e_latch, e_oe;
    logic [ROW_W-1:0] e_row;
    logic [COL_W-1:0] e_col;
    logic [PLANE_W-1:0] e_plane;
    int rem, len;
    e_rd_en = 1'b0; e_clk = 1'b0; e_latch = 1'b0; e_oe = 1'b1;
    e_row = '0; e_col = '0; e_plane = '0;
    if (m_on) begin
      rem = m_pos;
      for (int r = 0; r < ROWS; r++) begin
        for (int p = 0; p < PLANES; p++) begin
          len = 2 * COLS + BLANK_CYCLES + (BASE_TICKS << p);
          if (rem >= 0 && rem < len) begin
            e_row = ROW_W'(r);
            e_plane = PLANE_W'(p);
            if (rem < 2 * COLS) begin
              e_rd_en = (rem % 2 == 0);
              e_clk   = (rem % 2 == 1);
              e_col   = COL_W'(rem / 2);
              e_latch = m_lp && (rem >= 2 * COLS - 2);
            end else if (rem < 2 * COLS + BLANK_CYCLES) begin
              if (rem == 2 * COLS) begin
                e_latch = !m_lp;
                m_addr  = 5'(r);
              end
            end else begin
              e_oe = 1'b0;
            end
          end
          rem -= len;
        end
      end
    end
    v = {e_rd_en, e_row, e_col, e_plane, e_clk, e_latch, e_oe, m_addr, m_fd, logic'(m_on)};
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic en, input logic lp, input string tag);
    logic [VW-1:0] e, got;
    rst = r; enable = en; latch_pos = lp;
    if (r) begin
      m_on = 0; m_pos = 0; m_addr = '0; m_fd = 1'b0; m_lp = 1'b0;
    end else if (!m_on) begin
      m_fd = 1'b0;
      if (en) begin m_on = 1; m_pos = 0; m_lp = lp; end
    end else if (m_pos == FRAME - 1) begin
      m_fd = 1'b1; m_pos = 0;
      if (en) m_lp = lp;
      else    m_on = 0;
    end else begin
      m_pos++; m_fd = 1'b0;
    end
    build_exp(e);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    got = dut_vec;
    e = exp_q.pop_front();
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, e);
    end
    if (hub_clk && !prev_clk) clk_rise++;
    if (!hub_oe) oe_low++;
    if (hub_latch) latch_cnt++;
    if (hub_latch && hub_clk) latch_clk++;
    if (frame_done) begin
      if (gap_chk && last_fd >= 0) check_int("frame_done_gap", cyc - last_fd, FRAME);
      last_fd = cyc;
    end
    prev_clk = hub_clk;
  endtask

  task automatic clear_stats();
    clk_rise = 0; oe_low = 0; latch_cnt = 0; latch_clk = 0; last_fd = -1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; latch_pos = 1'b0; prev_clk = 1'b0; gap_chk = 0;
    clear_stats();
    @(negedge clk);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, "reset");

    // Continuous run, MBI5124 latch timing.
    clear_stats();
    for (int i = 0; i < FRAME; i++) step(1'b0, 1'b1, 1'b0, "run_mbi");
    check_int("clk_rises_per_frame", clk_rise, ROWS * PLANES * COLS);
    check_int("oe_low_per_frame", oe_low, ROWS * BASE_TICKS * ((1 << PLANES) - 1));
    check_int("latch_mbi_cycles", latch_cnt, ROWS * PLANES);
    check_int("latch_mbi_with_clk", latch_clk, 0);
    gap_chk = 1;
    for (int i = 0; i < FRAME + 1; i++) step(1'b0, 1'b1, 1'b0, "run_mbi_gap");
    gap_chk = 0;

    // ICN2038 latch timing from a fresh start.
    step(1'b1, 1'b0, 1'b0, "reset_icn");
    clear_stats();
    for (int i = 0; i < FRAME; i++) step(1'b0, 1'b1, 1'b1, "run_icn");
    check_int("latch_icn_cycles", latch_cnt, ROWS * PLANES * 2);
    check_int("latch_icn_with_clk", latch_clk, ROWS * PLANES);

    // LATCH_POS wiggling mid-frame only matters at frame starts.
    for (int i = 0; i < 2 * FRAME; i++)
      step(1'b0, 1'b1, 1'($urandom_range(0, 1)), "latch_toggle");

    // ENABLE dropped mid-frame: frame finishes, then idle, then restart.
    step(1'b1, 1'b0, 1'b0, "reset_en");
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, "en_run");
    for (int i = 0; i < FRAME - 20 + 6; i++) step(1'b0, 1'b0, 1'b0, "en_drop");
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b1, "en_restart");

    // Reset during display of row 1, plane 1.
    step(1'b1, 1'b0, 1'b0, "reset_pre");
    for (int i = 0; i < 29 + 13 + 10 + 2; i++) step(1'b0, 1'b1, 1'b0, "pre_reset_run");
    step(1'b1, 1'b1, 1'b0, "reset_mid");
    step(1'b0, 1'b0, 1'b0, "post_reset_idle");
    step(1'b0, 1'b0, 1'b0, "post_reset_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
